// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a one-deep
// holding register with valid/ack handshake, framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CYCLES = 10416,
  parameter int unsigned HALF   = CYCLES / 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CYCLES);
  localparam logic [CW-1:0] HalfLast = CW'(HALF - 1);
  localparam logic [CW-1:0] BitLast  = CW'(CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rx_m, rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          count_d = '0;
        end
      end
      StStart: begin
        if (count_q != HalfLast) begin
          count_d = count_q + CW'(1);
        end else if (!rx_s) begin
          state_d   = StData;
          count_d   = '0;
          bit_idx_d = '0;
        end else begin
          // Start bit gone high by mid-bit: treat as a glitch.
          state_d = StIdle;
        end
      end
      StData: begin
        if (count_q != BitLast) begin
          count_d = count_q + CW'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          count_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (count_q != BitLast) begin
          count_d = count_q + CW'(1);
        end else begin
          count_d = '0;
          if (rx_s) begin
            // Leave at mid-stop-bit so the next start edge is not missed.
            state_d = StIdle;
            if (!valid_q || ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // Hold off until the line recovers so a break is not read as 0x00s.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are queued as line waveforms and a
// frame-level model predicts delivery time, handshake state, flags and busy.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(
    .CYCLES(C),
    .HALF  (H)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ack      (ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  typedef struct {
    int         t;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t  ev_q[$];
  bit   line_q[$];
  int   busy_lo[$];
  int   busy_hi[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ack_mode = 0;  // 0 never, 1 random, 2 on every valid cycle

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic m_busy(input int k);
    if (!reset_n) return 1'b0;
    foreach (busy_lo[i]) begin
      if (k >= busy_lo[i] && k <= busy_hi[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Advance one clock: update the model for the end of cycle cyc, then check cycle cyc+1.
  task automatic tick();
    ev_t        ev;
    logic       nv;
    logic [7:0] nd;
    logic       fe;
    logic       ov;
    @(posedge clk);
    if (!reset_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
    end else begin
      nv = m_valid & ~ack;
      nd = m_data;
      fe = 1'b0;
      ov = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].t == cyc) begin
        ev = ev_q.pop_front();
        if (!ev.ok) begin
          fe = 1'b1;
        end else if (!m_valid || ack) begin
          nd = ev.b;
          nv = 1'b1;
        end else begin
          ov = 1'b1;
        end
      end
      m_valid = nv;
      m_data  = nd;
      m_fe    = fe;
      m_ov    = ov;
    end
    cyc++;
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("data", 32'(data), 32'(m_data));
    chk("frame_err", 32'(frame_err), 32'(m_fe));
    chk("overrun", 32'(overrun), 32'(m_ov));
    chk("busy", 32'(busy), 32'(m_busy(cyc)));
  endtask

  task automatic step();
    tick();
    rx = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
    case (ack_mode)
      1:       ack = ($urandom_range(0, 2) == 0);
      2:       ack = m_valid;
      default: ack = 1'b0;
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) line_q.push_back(1'b1);
  endtask

  // Queue one frame; returns its start cycle. expect_ev=0 means it will be cut by reset.
  task automatic send(input logic [7:0] b, input bit stop, input int extra_low,
                      input bit expect_ev, output int e);
    ev_t ev;
    e = cyc + 1 + line_q.size();
    for (int i = 0; i < C; i++) line_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < C; i++) line_q.push_back(b[k]);
    end
    for (int i = 0; i < C; i++) line_q.push_back(stop);
    for (int i = 0; i < extra_low; i++) line_q.push_back(1'b0);
    busy_lo.push_back(e + 3);
    if (stop) busy_hi.push_back(e + 2 + H + 9 * C);
    else      busy_hi.push_back(e + 10 * C + extra_low + 2);
    if (expect_ev) begin
      ev.t  = e + 2 + H + 9 * C;
      ev.b  = b;
      ev.ok = stop;
      ev_q.push_back(ev);
    end
  endtask

  task automatic drain(input int extra);
    while (line_q.size() > 0) step();
    repeat (extra) step();
  endtask

  int e;
  int g;

  initial begin
    repeat (3) step();
    chk("rst_state", {24'h0, data}, 32'h0);
    reset_n = 1'b1;
    idle(5);
    drain(0);

    // 0x55, acked by the pulse-on-valid policy.
    ack_mode = 2;
    send(8'h55, 1'b1, 0, 1'b1, e);
    drain(6);
    chk("lat55_data", 32'(data), 32'h55);

    // Back-to-back pair.
    send(8'hA3, 1'b1, 0, 1'b1, e);
    send(8'h3C, 1'b1, 0, 1'b1, e);
    drain(6);

    // Overrun: no ack for either byte, then consume.
    ack_mode = 0;
    send(8'h11, 1'b1, 0, 1'b1, e);
    idle(10);
    send(8'h22, 1'b1, 0, 1'b1, e);
    drain(4);
    chk("ovr_hold", 32'(data), 32'h11);
    ack_mode = 2;
    repeat (3) step();

    // Bad stop bit followed by a held-low line, then a good byte.
    send(8'h7E, 1'b0, 40, 1'b1, e);
    idle(20);
    send(8'h81, 1'b1, 0, 1'b1, e);
    drain(6);
    chk("after_break", 32'(data), 32'h81);

    // Short glitch on an idle line.
    g = cyc + 1 + line_q.size();
    line_q.push_back(1'b0);
    line_q.push_back(1'b0);
    line_q.push_back(1'b0);
    busy_lo.push_back(g + 3);
    busy_hi.push_back(g + 2 + H);
    idle(20);
    drain(0);

    // Leave a byte pending, then reset in the middle of bit 4 of 0xF0.
    ack_mode = 0;
    send(8'h5A, 1'b1, 0, 1'b1, e);
    idle(4);
    drain(0);
    send(8'hF0, 1'b1, 0, 1'b0, e);
    while (cyc < e + 5 * C + H + 2) step();
    reset_n = 1'b0;
    line_q.delete();
    ev_q.delete();
    busy_lo.delete();
    busy_hi.delete();
    rx = 1'b1;
    #1;
    chk("rst_async", {data, valid, frame_err, overrun, busy}, 12'h0);
    repeat (3) step();
    reset_n = 1'b1;
    ack_mode = 2;
    idle(5);
    send(8'h0F, 1'b1, 0, 1'b1, e);
    drain(6);
    chk("post_rst", 32'(data), 32'h0F);

    // Random bytes, gaps, acks and occasional bad stop bits.
    ack_mode = 1;
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        send(8'($urandom), 1'b0, int'($urandom_range(0, 30)), 1'b1, e);
      end else begin
        send(8'($urandom), 1'b1, 0, 1'b1, e);
      end
      idle(int'($urandom_range(2, 15)));
    end
    drain(10);
    ack_mode = 2;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the board UART link, 8N1, LSB first; directly downstream of the transmitter on the same framing and bit timing.
- Samples the asynchronous `rx` line mid-bit and assembles bytes.
- Presents each byte in a one-deep holding register with a valid/ack handshake to the consuming logic (console/command decoder).
- Flags framing errors and overruns.

Parameters:
- CYCLES, 10416, clock cycles per bit (100 MHz / 9600 baud); must be >= 8.
- HALF, CYCLES/2 (integer divide), cycles from the start-bit edge to the mid-start-bit sample.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  reset, asynchronous assert, active-low.
- rx  input  1  serial line, asynchronous to clk; idles high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  byte available in holding register.
- ack  input  1  consumer takes byte; meaningful only when valid=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte dropped because holding register still full.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; count=0; bit_idx=0; shift=0.
  - Both sync flops=1.
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
- Synchroniser:
  - rx passes through 2 flops (rx_m, rx_s). The FSM uses only rx_s.
  - A rx edge at cycle e is seen by the FSM in cycle e+2.
- FSM:
  - IDLE: rx_s=0 -> START, count=0.
  - START: count<HALF-1 -> count++. At count=HALF-1:
    - rx_s=0 -> DATA, count=0, bit_idx=0.
    - rx_s=1 -> IDLE (glitch rejected; no flags).
  - DATA: count<CYCLES-1 -> count++. At count=CYCLES-1:
    - shift <= {rx_s, shift[7:1]}; count=0.
    - bit_idx<7 -> bit_idx++.
    - bit_idx=7 -> STOP.
  - STOP: count<CYCLES-1 -> count++. At count=CYCLES-1, sample rx_s:
    - rx_s=1 -> deliver; go to IDLE.
    - rx_s=0 -> frame_err=1 for one cycle; byte discarded; go to BREAK.
  - BREAK: stay until rx_s=1, then IDLE. This prevents a held-low line (break) from being decoded as a stream of 0x00.
  - Other encodings -> IDLE.
- Return to IDLE at mid-stop-bit is deliberate: it leaves half a bit of margin to catch the next start edge.
- Deliver rules (registered; outputs change the cycle after the stop sample):
  - valid=0: data <= shift; valid <= 1.
  - valid=1 and ack=1 in the same cycle: data <= shift; valid stays 1.
  - valid=1 and ack=0: data unchanged, new byte dropped, overrun=1 for one cycle.
- Handshake:
  - Byte is consumed on any cycle with valid=1 and ack=1; valid <= 0 the next cycle unless a delivery coincides.
  - ack while valid=0 is ignored.
- Latency: rx falling edge at cycle e -> valid=1 first visible at cycle e+3+HALF+9*CYCLES.
- frame_err and overrun are never both high in one cycle.
- busy=1 in START/DATA/STOP/BREAK.
- Reset mid-frame: partial byte discarded and all outputs return to reset values immediately. Capture resumes on the next rx_s falling level seen in IDLE.
- count width: clog2(CYCLES); no wrap is possible since count is cleared at CYCLES-1.

Test Plan (CYCLES=16, HALF=8):
- Send 0x55 framed 8N1 at 16 cycles/bit, edge at e -> valid rises exactly at e+155, data=0x55; ack one cycle -> valid=0 next cycle.
- Back-to-back 0xA3 then 0x3C with ack pulsed on each valid -> data sequence 0xA3, 0x3C; frame_err=0, overrun=0 throughout.
- Send 0x11 with no ack, then 0x22 -> data stays 0x11, overrun pulses 1 cycle at the second byte's delivery time; ack -> valid=0, data=0x11 was the value taken.
- Stop bit driven low for 0x7E, line then held low 40 cycles -> frame_err pulses once, valid stays 0; no further frames until rx returns high; next good 0x81 received correctly.
- 3-cycle low glitch on idle rx -> FSM returns to IDLE at the HALF sample; no valid, no flags; busy high for ~HALF cycles then low.
- reset_n low during bit 4 of 0xF0, released, then send 0x0F -> all outputs 0 during reset; next valid shows data=0x0F, no frame_err.
